// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the hardwired control sequencer: step states, opcodes,
// ALU operation codes and the opcode-class decode used by next-state and output logic.
package cpu_ctrl_pkg;

    localparam int OP_W = 5;

    typedef enum logic [3:0] {
        RST_ST = 4'd0,
        T0     = 4'd1,
        T1     = 4'd2,
        T2     = 4'd3,
        T3     = 4'd4,
        T4     = 4'd5,
        T5     = 4'd6,
        T6     = 4'd7,
        T7     = 4'd8,
        HALTED = 4'd9
    } state_t;

    localparam logic [OP_W-1:0] OPC_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OPC_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OPC_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OPC_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OPC_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OPC_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OPC_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OPC_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OPC_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OPC_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OPC_HALT = 5'b11011;

    localparam logic [OP_W-1:0] OP_NONE = 5'b00000;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_MEM,
        CLS_RTYPE,
        CLS_IMM,
        CLS_MULDIV,
        CLS_HALT
    } op_class_t;

    // Anything not listed behaves as a nop, so it falls into CLS_NOP.
    function automatic op_class_t op_class(input logic [OP_W-1:0] opc);
        case (opc)
            OPC_LD, OPC_LDI, OPC_ST:             return CLS_MEM;
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR:   return CLS_RTYPE;
            OPC_ADDI, OPC_ANDI, OPC_ORI:         return CLS_IMM;
            OPC_MUL, OPC_DIV:                    return CLS_MULDIV;
            OPC_HALT:                            return CLS_HALT;
            default:                             return CLS_NOP;
        endcase
    endfunction

    function automatic logic [OP_W-1:0] imm_alu_op(input logic [OP_W-1:0] opc);
        case (opc)
            OPC_ANDI: return OP_AND;
            OPC_ORI:  return OP_OR;
            default:  return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave): IR in,
// every strobe plus the ALU op and Run out, and the step state for observation.
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic [31:0]     IR_data;
    logic            PCout, Zlowout, ZHighout, MDRout, Cout, BAout, Rout;
    logic            PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin;
    logic            IncPC, Read, Write;
    logic            GRA, GRB, GRC;
    logic [OP_W-1:0] operation;
    logic            Run;
    state_t          seq_state;

    modport master (
        input  IR_data,
        output PCout, Zlowout, ZHighout, MDRout, Cout, BAout, Rout,
        output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin,
        output IncPC, Read, Write, GRA, GRB, GRC, operation, Run, seq_state
    );

    modport slave (
        output IR_data,
        input  PCout, Zlowout, ZHighout, MDRout, Cout, BAout, Rout,
        input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin,
        input  IncPC, Read, Write, GRA, GRB, GRC, operation, Run, seq_state
    );

endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch in T0-T2, then per-opcode micro-steps T3-T7,
// looping to T0 after each instruction until a halt parks it in HALTED.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    control_sequencer_if.master  bus
);

    state_t          state_q, state_d;
    logic [OP_W-1:0] opcode;
    op_class_t       cls;

    // IR only loads in T2, so the live opcode is stable through T3-T7.
    assign opcode = bus.IR_data[31:27];
    assign cls    = op_class(opcode);

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= RST_ST;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST_ST: state_d = T0;
            T0:     state_d = T1;
            T1:     state_d = T2;
            T2:     state_d = T3;
            T3: begin
                if (cls == CLS_HALT)     state_d = HALTED;
                else if (cls == CLS_NOP) state_d = T0;
                else                     state_d = T4;
            end
            T4:     state_d = T5;
            T5: begin
                if (cls == CLS_MULDIV || (cls == CLS_MEM && opcode != OPC_LDI)) state_d = T6;
                else                                                            state_d = T0;
            end
            T6:     state_d = (cls == CLS_MULDIV) ? T0 : T7;
            T7:     state_d = T0;
            HALTED: state_d = HALTED;
            default: state_d = RST_ST;
        endcase
    end

    always_comb begin
        bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.ZHighout = 1'b0; bus.MDRout = 1'b0;
        bus.Cout  = 1'b0; bus.BAout   = 1'b0; bus.Rout     = 1'b0;
        bus.PCin  = 1'b0; bus.MARin   = 1'b0; bus.MDRin    = 1'b0; bus.IRin = 1'b0;
        bus.Yin   = 1'b0; bus.Zin     = 1'b0; bus.HIin     = 1'b0; bus.LOin = 1'b0;
        bus.Rin   = 1'b0; bus.IncPC   = 1'b0; bus.Read     = 1'b0; bus.Write = 1'b0;
        bus.GRA   = 1'b0; bus.GRB     = 1'b0; bus.GRC      = 1'b0;
        bus.operation = OP_NONE;
        bus.Run   = (state_q != RST_ST) && (state_q != HALTED);
        case (state_q)
            T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.PCin = 1'b1; end
            T1: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
            T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            T3: begin
                case (cls)
                    CLS_MEM:          begin bus.GRB = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                    CLS_RTYPE, CLS_IMM: begin bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    CLS_MULDIV:       begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                case (cls)
                    CLS_MEM: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.operation = OP_ADD; end
                    CLS_IMM: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.operation = imm_alu_op(opcode); end
                    CLS_RTYPE: begin
                        bus.GRC = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.operation = opcode;
                    end
                    CLS_MULDIV: begin
                        bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.operation = opcode;
                    end
                    default: ;
                endcase
            end
            T5: begin
                if (cls == CLS_MULDIV) begin
                    bus.Zlowout = 1'b1; bus.LOin = 1'b1;
                end else if (cls == CLS_MEM && opcode != OPC_LDI) begin
                    bus.Zlowout = 1'b1; bus.MARin = 1'b1;
                end else if (cls != CLS_NOP && cls != CLS_HALT) begin
                    bus.Zlowout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1;
                end
            end
            T6: begin
                if (cls == CLS_MULDIV) begin
                    bus.ZHighout = 1'b1; bus.HIin = 1'b1;
                end else if (opcode == OPC_ST) begin
                    bus.GRA = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                end else if (opcode == OPC_LD) begin
                    bus.Read = 1'b1; bus.MDRin = 1'b1;
                end
            end
            T7: begin
                if (opcode == OPC_ST)      bus.Write = 1'b1;
                else if (opcode == OPC_LD) begin bus.MDRout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
            end
            default: ;
        endcase
    end

    assign bus.seq_state = state_q;

endmodule
